// File: rtl/parking_pkg.sv
// Shared types and defaults for the car park barrier gate logic.
package parking_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OPEN  = 2'd1,
      CLOSE = 2'd2
   } gate_state_t;

   typedef enum logic {
      LANE_ENTRY = 1'b0,
      LANE_EXIT  = 1'b1
   } lane_t;

   localparam int DEFAULT_CAPACITY = 64;

endpackage

// File: rtl/parking_rr_arbiter.sv
// Two-lane grant picker. With PARKING_EXIT_PRIORITY_EN defined exit always wins a tie,
// otherwise ties alternate using a last_served register.
module parking_rr_arbiter
   import parking_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic entry_elig,
   input  logic exit_elig,
   output logic grant_entry,
   output logic grant_exit
);

`ifdef PARKING_EXIT_PRIORITY_EN
   logic unused_clk_reset;
   assign unused_clk_reset = clk ^ reset;

   always_comb begin
      grant_exit  = en && exit_elig;
      grant_entry = en && entry_elig && !exit_elig;
   end
`else
   lane_t last_served;

   // On a tie the lane not served most recently wins.
   always_comb begin
      grant_entry = en && entry_elig && (!exit_elig || last_served == LANE_EXIT);
      grant_exit  = en && exit_elig && (!entry_elig || last_served == LANE_ENTRY);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_served <= LANE_EXIT;
      end else if (grant_entry) begin
         last_served <= LANE_ENTRY;
      end else if (grant_exit) begin
         last_served <= LANE_EXIT;
      end
   end
`endif

endmodule

// File: rtl/parking_gate_arbiter.sv
// Shares one barrier gate between entry and exit lanes and tracks slot occupancy.
// Optional macro PARKING_EXIT_PRIORITY_EN makes exit win every tie.
module parking_gate_arbiter
   import parking_pkg::*;
#(
   parameter int CAPACITY    = DEFAULT_CAPACITY,
   parameter int CNT_W       = 7,
   parameter int OPEN_CYCLES = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             entry_req,
   input  logic             exit_req,
   input  logic             pass_done,
   output logic             entry_ack,
   output logic             exit_ack,
   output logic             gate_open,
   output logic [CNT_W-1:0] occupancy,
   output logic             full,
   output logic             empty,
   output logic             timeout_err
);

   localparam int TMR_W = 4;

   gate_state_t      state;
   lane_t            lane;
   logic [TMR_W-1:0] timer;
   logic             grant_entry;
   logic             grant_exit;

   assign full  = (occupancy == CNT_W'(CAPACITY));
   assign empty = (occupancy == '0);

   parking_rr_arbiter u_arb (
      .clk         (clk),
      .reset       (reset),
      .en          (state == IDLE),
      .entry_elig  (entry_req && !full),
      .exit_elig   (exit_req && !empty),
      .grant_entry (grant_entry),
      .grant_exit  (grant_exit)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         lane        <= LANE_ENTRY;
         timer       <= '0;
         occupancy   <= '0;
         entry_ack   <= 1'b0;
         exit_ack    <= 1'b0;
         gate_open   <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         entry_ack   <= 1'b0;
         exit_ack    <= 1'b0;
         timeout_err <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_entry || grant_exit) begin
                  lane      <= grant_exit ? LANE_EXIT : LANE_ENTRY;
                  entry_ack <= grant_entry;
                  exit_ack  <= grant_exit;
                  gate_open <= 1'b1;
                  timer     <= '0;
                  state     <= OPEN;
               end
            end
            OPEN: begin
               timer <= timer + 1'b1;
               // A pass in the expiry cycle still counts as a pass.
               if (pass_done) begin
                  if (lane == LANE_ENTRY) occupancy <= occupancy + 1'b1;
                  else                    occupancy <= occupancy - 1'b1;
                  gate_open <= 1'b0;
                  state     <= CLOSE;
               end else if (timer == TMR_W'(OPEN_CYCLES - 1)) begin
                  timeout_err <= 1'b1;
                  gate_open   <= 1'b0;
                  state       <= CLOSE;
               end
            end
            CLOSE: begin
               state <= IDLE;
            end
            default: begin
               gate_open <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Scoreboard bench for parking_gate_arbiter with a 4-slot lot and an 8-cycle gate window.
module tb_parking_gate_arbiter;

   localparam int CAP = 4;
   localparam int CW  = 7;
   localparam int OC  = 8;
   localparam int K_ENT = 0;
   localparam int K_EXT = 1;
   localparam int K_TO  = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          entry_req = 1'b0;
   logic          exit_req = 1'b0;
   logic          pass_done = 1'b0;
   logic          entry_ack, exit_ack, gate_open, full, empty, timeout_err;
   logic [CW-1:0] occupancy;

   typedef struct {
      int kind;
      int occ;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   occ_m  = 0;

   always #5 clk = ~clk;

   parking_gate_arbiter #(
      .CAPACITY    (CAP),
      .CNT_W       (CW),
      .OPEN_CYCLES (OC)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .entry_req   (entry_req),
      .exit_req    (exit_req),
      .pass_done   (pass_done),
      .entry_ack   (entry_ack),
      .exit_ack    (exit_ack),
      .gate_open   (gate_open),
      .occupancy   (occupancy),
      .full        (full),
      .empty       (empty),
      .timeout_err (timeout_err)
   );

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   // Monitor: every ack or timeout pulse must match the next expected event.
   always @(negedge clk) begin
      if (reset && (entry_ack || exit_ack || timeout_err)) begin
         int   k;
         exp_t e;
         if (int'(entry_ack) + int'(exit_ack) + int'(timeout_err) > 1) k = 3;
         else if (entry_ack) k = K_ENT;
         else if (exit_ack)  k = K_EXT;
         else                k = K_TO;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d expected none", k);
         end else begin
            e = exp_q.pop_front();
            chk("event_kind", k, e.kind);
            chk("event_occ", int'(occupancy), e.occ);
         end
      end
   end

   task automatic wait_ack(input bit ent, output int cyc);
      cyc = 0;
      while (!(ent ? entry_ack : exit_ack) && cyc < 30) begin
         @(negedge clk);
         cyc++;
      end
      if (!(ent ? entry_ack : exit_ack)) begin
         checks++;
         errors++;
         $display("FAIL ack_wait: got no ack expected ack within 30 cycles");
      end
   endtask

   task automatic check_flags();
      chk("full_flag", int'(full), (occ_m == CAP) ? 1 : 0);
      chk("empty_flag", int'(empty), (occ_m == 0) ? 1 : 0);
   endtask

   // One granted transaction; n_open = gate cycle carrying pass_done, 0 = let it time out.
   task automatic txn(input bit ent, input int n_open);
      int cyc;
      int gate_cnt;
      bit gate_bad;
      gate_bad = 1'b0;
      exp_q.push_back('{ent ? K_ENT : K_EXT, occ_m});
      if (n_open == 0) exp_q.push_back('{K_TO, occ_m});
      @(negedge clk);
      if (ent) entry_req = 1'b1;
      else     exit_req  = 1'b1;
      wait_ack(ent, cyc);
      entry_req = 1'b0;
      exit_req  = 1'b0;
      chk("gate_open_at_ack", int'(gate_open), 1);
      if (n_open > 0) begin
         for (int c = 1; c < n_open; c++) begin
            @(negedge clk);
            if (!gate_open) gate_bad = 1'b1;
         end
         pass_done = 1'b1;
         @(negedge clk);
         pass_done = 1'b0;
         occ_m += ent ? 1 : -1;
         chk("gate_held_open", int'(gate_bad), 0);
         chk("gate_closed_after_pass", int'(gate_open), 0);
         chk("occ_after_pass", int'(occupancy), occ_m);
      end else begin
         gate_cnt = 0;
         while (gate_open && gate_cnt < 20) begin
            gate_cnt++;
            @(negedge clk);
         end
         chk("gate_window_cycles", gate_cnt, OC);
         chk("occ_after_timeout", int'(occupancy), occ_m);
      end
      check_flags();
   endtask

   task automatic no_grant(input bit ent, input bit hold);
      int acks;
      int opens;
      acks  = 0;
      opens = 0;
      @(negedge clk);
      if (ent) entry_req = 1'b1;
      else     exit_req  = 1'b1;
      repeat (12) begin
         @(negedge clk);
         if (ent ? entry_ack : exit_ack) acks++;
         if (gate_open) opens++;
      end
      chk("ineligible_no_ack", acks, 0);
      chk("ineligible_gate_closed", opens, 0);
      if (!hold) begin
         entry_req = 1'b0;
         exit_req  = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cyc;
      int o;
      int lanes[4];

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_entry_ack", int'(entry_ack), 0);
      chk("rst_exit_ack", int'(exit_ack), 0);
      chk("rst_gate_open", int'(gate_open), 0);
      chk("rst_timeout_err", int'(timeout_err), 0);
      chk("rst_occupancy", int'(occupancy), 0);
      chk("rst_full", int'(full), 0);
      chk("rst_empty", int'(empty), 1);
      reset = 1'b1;

      // Exit on an empty lot, then a stray pass in IDLE
      no_grant(1'b0, 1'b0);
      @(negedge clk);
      pass_done = 1'b1;
      @(negedge clk);
      pass_done = 1'b0;
      @(negedge clk);
      chk("idle_pass_occ", int'(occupancy), 0);
      chk("idle_pass_gate", int'(gate_open), 0);

      // Entry with pass in third gate cycle, then a timed-out entry
      txn(1'b1, 3);
      txn(1'b1, 0);

      // Fill the lot
      txn(1'b1, 1);
      txn(1'b1, 2);
      txn(1'b1, 5);
      chk("full_after_fill", int'(full), 1);

      // Full lot blocks entry; an exit frees a slot and entry follows at best-case turnaround
      no_grant(1'b1, 1'b1);
      exp_q.push_back('{K_EXT, 4});
      exp_q.push_back('{K_ENT, 3});
      @(negedge clk);
      exit_req = 1'b1;
      wait_ack(1'b0, cyc);
      exit_req  = 1'b0;
      pass_done = 1'b1;
      @(negedge clk);
      pass_done = 1'b0;
      occ_m = 3;
      chk("occ_after_exit", int'(occupancy), 3);
      chk("not_full_after_exit", int'(full), 0);
      wait_ack(1'b1, cyc);
      chk("turnaround_cycles", cyc + 1, 3);
      entry_req = 1'b0;
      pass_done = 1'b1;
      @(negedge clk);
      pass_done = 1'b0;
      occ_m = 4;
      chk("occ_refilled", int'(occupancy), 4);

      // Down to 2, then reset while the gate is open
      txn(1'b0, 2);
      txn(1'b0, 1);
      exp_q.push_back('{K_ENT, 2});
      @(negedge clk);
      entry_req = 1'b1;
      wait_ack(1'b1, cyc);
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("async_gate_drop", int'(gate_open), 0);
      chk("async_occ_clear", int'(occupancy), 0);
      occ_m = 0;
      exp_q.push_back('{K_ENT, 0});
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("regrant_after_reset", int'(entry_ack), 1);
      entry_req = 1'b0;
      pass_done = 1'b1;
      @(negedge clk);
      pass_done = 1'b0;
      occ_m = 1;
      chk("occ_after_regrant", int'(occupancy), 1);

      // Both lanes held with occupancy 2
      txn(1'b1, 1);
`ifdef PARKING_EXIT_PRIORITY_EN
      lanes = '{1, 1, 0, 1};
`else
      lanes = '{1, 0, 1, 0};
`endif
      o = occ_m;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back('{(lanes[i] != 0) ? K_EXT : K_ENT, o});
         o += (lanes[i] != 0) ? -1 : 1;
      end
      @(negedge clk);
      entry_req = 1'b1;
      exit_req  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc = 0;
         while (!(entry_ack || exit_ack) && cyc < 30) begin
            @(negedge clk);
            cyc++;
         end
         chk("tie_grant_seen", int'(entry_ack || exit_ack), 1);
         if (i == 3) begin
            entry_req = 1'b0;
            exit_req  = 1'b0;
         end
         pass_done = 1'b1;
         @(negedge clk);
         pass_done = 1'b0;
         occ_m += (lanes[i] != 0) ? -1 : 1;
         chk("tie_occ", int'(occupancy), occ_m);
      end

      repeat (4) @(negedge clk);
      chk("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
